// File: rtl/uart_pkg.sv
// Shared types, baud constants and helpers for the frame transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        ParNone = 2'b00,
        ParEven = 2'b01,
        ParOdd  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam int unsigned Baud9600   = 9600;
    localparam int unsigned Baud19200  = 19200;
    localparam int unsigned Baud38400  = 38400;
    localparam int unsigned Baud57600  = 57600;
    localparam int unsigned Baud115200 = 115200;

    function automatic int unsigned baud_div(int unsigned clk_freq, logic [2:0] sel);
        case (sel)
            3'd0:    return clk_freq / Baud9600;
            3'd1:    return clk_freq / Baud19200;
            3'd2:    return clk_freq / Baud38400;
            3'd3:    return clk_freq / Baud57600;
            default: return clk_freq / Baud115200;
        endcase
    endfunction

    function automatic parity_e decode_parity(logic [1:0] mode);
        case (mode)
            2'b01:   return ParEven;
            2'b10:   return ParOdd;
            default: return ParNone;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmitter with input FIFO, runtime baud/parity/stop selection and
// back-to-back framing.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [DATA_BITS-1:0]          Data_in,
    input  logic                          Data_valid,
    output logic                          Data_ready,
    input  logic                          Tx_en,
    input  logic [2:0]                    Baud_set,
    input  logic [1:0]                    Parity_mode,
    input  logic                          Stop2,
    output logic                          Uart_tx,
    output logic                          Tx_done,
    output logic                          Uart_state,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_count
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DivW = $clog2(baud_div(CLK_FREQ, 3'd0) + 1);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam logic [DivW-1:0] Div0 = DivW'(baud_div(CLK_FREQ, 3'd0));
    localparam logic [DivW-1:0] Div1 = DivW'(baud_div(CLK_FREQ, 3'd1));
    localparam logic [DivW-1:0] Div2 = DivW'(baud_div(CLK_FREQ, 3'd2));
    localparam logic [DivW-1:0] Div3 = DivW'(baud_div(CLK_FREQ, 3'd3));
    localparam logic [DivW-1:0] Div4 = DivW'(baud_div(CLK_FREQ, 3'd4));

    state_e                state_q, state_d;
    logic [DivW-1:0]       div_q, div_sel, baud_cnt_q;
    logic [BitW-1:0]       bit_cnt_q;
    logic [DATA_BITS-1:0]  shift_q, fifo_data;
    logic                  par_en_q, par_bit_q, stop2_q;
    logic                  tx_q, tx_d, busy_q, busy_d;
    logic                  fifo_full, fifo_empty, fifo_push, pop;
    logic                  bit_end, last_data, last_stop, can_start;
    logic [CntW-1:0]       count_next;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (fifo_push),
        .wr_data (Data_in),
        .pop     (pop),
        .rd_data (fifo_data),
        .count   (Fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign Data_ready = ~fifo_full;
    assign fifo_push  = Data_valid & Data_ready;
    assign can_start  = ~fifo_empty & Tx_en;
    assign bit_end    = (baud_cnt_q == div_q - DivW'(1));
    assign last_data  = (bit_cnt_q == BitW'(DATA_BITS - 1));
    assign last_stop  = ~stop2_q | (bit_cnt_q == BitW'(1));
    assign count_next = Fifo_count + CntW'(fifo_push) - CntW'(pop);
    assign busy_d     = (state_d != StIdle) | (count_next != '0);
    assign Uart_tx    = tx_q;
    assign Uart_state = busy_q;

    always_comb begin
        case (Baud_set)
            3'd0:    div_sel = Div0;
            3'd1:    div_sel = Div1;
            3'd2:    div_sel = Div2;
            3'd3:    div_sel = Div3;
            default: div_sel = Div4;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (can_start) state_d = StStart;
            StStart:  if (bit_end) state_d = StData;
            StData:   if (bit_end && last_data) state_d = par_en_q ? StParity : StStop;
            StParity: if (bit_end) state_d = StStop;
            StStop:   if (bit_end && last_stop) state_d = can_start ? StStart : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // tx_d is the level for the next cycle, so the line leaves a flop.
    always_comb begin
        pop     = 1'b0;
        tx_d    = tx_q;
        Tx_done = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (can_start) begin
                    pop  = 1'b1;
                    tx_d = 1'b0;
                end
            end
            StStart:  if (bit_end) tx_d = shift_q[0];
            StData: begin
                if (bit_end) tx_d = last_data ? (par_en_q ? par_bit_q : 1'b1) : shift_q[1];
            end
            StParity: if (bit_end) tx_d = 1'b1;
            StStop: begin
                if (bit_end && last_stop) begin
                    Tx_done = 1'b1;
                    pop     = can_start;
                    tx_d    = ~can_start;
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            div_q      <= Div4;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            if (pop) begin
                baud_cnt_q <= '0;
                bit_cnt_q  <= '0;
                div_q      <= div_sel;
                shift_q    <= fifo_data;
                par_en_q   <= (decode_parity(Parity_mode) != ParNone);
                par_bit_q  <= (decode_parity(Parity_mode) == ParOdd) ^ (^fifo_data);
                stop2_q    <= Stop2;
            end else if (state_q != StIdle) begin
                baud_cnt_q <= bit_end ? '0 : baud_cnt_q + DivW'(1);
                if (bit_end) begin
                    // bit_cnt_q indexes data bits, then restarts to index stop bits.
                    case (state_q)
                        StData: begin
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= last_data ? '0 : bit_cnt_q + BitW'(1);
                        end
                        StStop:  bit_cnt_q <= bit_cnt_q + BitW'(1);
                        default: bit_cnt_q <= '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench: three DUT builds driven in parallel, per-instance line monitors.
module tb_uart_frame_tx;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
        bit          b2b;
        int          check_len;
        logic [15:0] tag;
    } frame_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic       rst_ab_n, rst_c_n;
    logic [7:0] din_a, din_b;
    logic [6:0] din_c;
    logic       valid_a, valid_b, valid_c, ready_a, ready_b, ready_c;
    logic       en_a, en_b, en_c, stop2_a, stop2_b, stop2_c;
    logic [2:0] baud_a, baud_b, baud_c, count_a, count_b, count_c;
    logic [1:0] par_a, par_b, par_c;
    logic       tx_a, tx_b, tx_c, done_a, done_b, done_c, busy_a, busy_b, busy_c;

    uart_frame_tx #(.CLK_FREQ(50_000_000), .DATA_BITS(8), .FIFO_DEPTH(4)) u_main (
        .Clk(Clk), .Reset_n(rst_ab_n), .Data_in(din_a), .Data_valid(valid_a),
        .Data_ready(ready_a), .Tx_en(en_a), .Baud_set(baud_a), .Parity_mode(par_a),
        .Stop2(stop2_a), .Uart_tx(tx_a), .Tx_done(done_a), .Uart_state(busy_a),
        .Fifo_count(count_a));

    uart_frame_tx #(.CLK_FREQ(50_000_000), .DATA_BITS(8), .FIFO_DEPTH(4)) u_slow (
        .Clk(Clk), .Reset_n(rst_ab_n), .Data_in(din_b), .Data_valid(valid_b),
        .Data_ready(ready_b), .Tx_en(en_b), .Baud_set(baud_b), .Parity_mode(par_b),
        .Stop2(stop2_b), .Uart_tx(tx_b), .Tx_done(done_b), .Uart_state(busy_b),
        .Fifo_count(count_b));

    uart_frame_tx #(.CLK_FREQ(50_000_000), .DATA_BITS(7), .FIFO_DEPTH(4)) u_db7 (
        .Clk(Clk), .Reset_n(rst_c_n), .Data_in(din_c), .Data_valid(valid_c),
        .Data_ready(ready_c), .Tx_en(en_c), .Baud_set(baud_c), .Parity_mode(par_c),
        .Stop2(stop2_c), .Uart_tx(tx_c), .Tx_done(done_c), .Uart_state(busy_c),
        .Fifo_count(count_c));

    int     n_checks = 0;
    int     n_fail = 0;
    frame_t q_a[$], q_b[$], q_c[$];
    bit     mon_busy [3];
    int     prev_end [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic get_tx(input int id);
        case (id)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_done(input int id);
        case (id)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic frame_t pop_exp(input int id);
        case (id)
            0:       return q_a.pop_front();
            1:       return q_b.pop_front();
            default: return q_c.pop_front();
        endcase
    endfunction

    task automatic expect_frame(input int id, input logic [15:0] bits, input int nbits,
                                input int div, input bit b2b, input int check_len,
                                input logic [15:0] tag);
        frame_t f;
        f.bits = bits; f.nbits = nbits; f.div = div; f.b2b = b2b;
        f.check_len = check_len; f.tag = tag;
        case (id)
            0:       q_a.push_back(f);
            1:       q_b.push_back(f);
            default: q_c.push_back(f);
        endcase
    endtask

    function automatic logic [15:0] frame_8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Compares every cycle of a frame against the expected bit levels.
    task automatic monitor(input int id);
        frame_t f;
        int len, bad, first_bad, dbad, first_dbad, start, t;
        forever begin
            @(negedge Clk);
            if (get_tx(id) === 1'b0) begin
                mon_busy[id] = 1'b1;
                start = cyc;
                if (qsize(id) == 0) begin
                    check($sformatf("mon%0d_unexpected_start", id), 1, 0);
                    t = 0;
                    while (get_tx(id) === 1'b0 && t < 60000) begin
                        @(negedge Clk);
                        t++;
                    end
                end else begin
                    f = pop_exp(id);
                    if (f.b2b) check($sformatf("mon%0d_b2b_start tag=%0h", id, f.tag),
                                     start, prev_end[id] + 1);
                    len = (f.check_len != 0) ? f.check_len : f.nbits * f.div;
                    bad = 0; dbad = 0; first_bad = 0; first_dbad = 0;
                    for (int k = 0; k < len; k++) begin
                        if (k > 0) @(negedge Clk);
                        if (get_tx(id) !== f.bits[k / f.div]) begin
                            if (bad == 0) first_bad = k;
                            bad++;
                        end
                        if (get_done(id) !== (k == f.nbits * f.div - 1)) begin
                            if (dbad == 0) first_dbad = k;
                            dbad++;
                        end
                    end
                    prev_end[id] = cyc;
                    check($sformatf("mon%0d_line tag=%0h first_bad_cycle=%0d", id, f.tag,
                                    first_bad), bad, 0);
                    check($sformatf("mon%0d_tx_done tag=%0h first_bad_cycle=%0d", id, f.tag,
                                    first_dbad), dbad, 0);
                end
                mon_busy[id] = 1'b0;
            end else if (get_done(id) === 1'b1) begin
                check($sformatf("mon%0d_stray_tx_done", id), 1, 0);
            end
        end
    endtask

    task automatic wait_drain(input int id, input int budget);
        int t = 0;
        while ((qsize(id) != 0 || mon_busy[id]) && t < budget) begin
            @(negedge Clk);
            t++;
        end
        check($sformatf("drain%0d_timeout", id), (t >= budget), 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic run_a();
        logic [7:0] words [6];
        logic       exp_ready [6];
        int t;
        words     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        // 8N1 at 115200: latency, frame, Tx_done and busy fall
        en_a = 1'b1; baud_a = 3'b100; par_a = 2'b00; stop2_a = 1'b0;
        expect_frame(0, 16'b0000_0011_0100_1010, 10, 434, 1'b0, 0, 16'hA5);
        valid_a = 1'b1; din_a = 8'hA5;
        @(negedge Clk);
        valid_a = 1'b0;
        check("latency_line_still_high", tx_a, 1);
        check("count_after_push", count_a, 1);
        @(negedge Clk);
        check("latency_start_bit", tx_a, 0);
        t = 0;
        while (done_a !== 1'b1 && t < 5000) begin
            @(negedge Clk);
            t++;
        end
        check("done_after_start", t, 4339);
        check("busy_at_done", busy_a, 1);
        @(negedge Clk);
        check("busy_falls_after_done", busy_a, 0);
        check("line_idle_after_frame", tx_a, 1);
        wait_drain(0, 100);
        // Even then odd parity, back to back
        par_a = 2'b01;
        expect_frame(0, 16'b0000_0101_0100_1010, 11, 434, 1'b0, 0, 16'hA5);
        expect_frame(0, 16'b0000_0111_0100_1010, 11, 434, 1'b1, 0, 16'hA5);
        valid_a = 1'b1; din_a = 8'hA5;
        @(negedge Clk);
        @(negedge Clk);
        valid_a = 1'b0; par_a = 2'b10;
        wait_drain(0, 10000);
        // Fill with Tx_en low: words 5 and 6 dropped
        par_a = 2'b00; en_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid_a = 1'b1; din_a = words[i];
            check($sformatf("ready_before_push%0d", i), ready_a, exp_ready[i]);
            @(negedge Clk);
        end
        valid_a = 1'b0;
        check("count_full", count_a, 4);
        repeat (50) @(negedge Clk);
        check("line_high_while_disabled", tx_a, 1);
        check("count_held_while_disabled", count_a, 4);
        for (int i = 0; i < 4; i++)
            expect_frame(0, frame_8n1(words[i]), 10, 434, (i != 0), 0, 16'(words[i]));
        en_a = 1'b1;
        wait_drain(0, 20000);
        check("count_after_flush", count_a, 0);
        check("busy_after_flush", busy_a, 0);
        // Tx_en dropped mid-frame: frame completes, next word held
        expect_frame(0, frame_8n1(8'h3C), 10, 434, 1'b0, 0, 16'h3C);
        valid_a = 1'b1; din_a = 8'h3C;
        @(negedge Clk);
        din_a = 8'hC3;
        @(negedge Clk);
        valid_a = 1'b0;
        repeat (1000) @(negedge Clk);
        en_a = 1'b0;
        wait_drain(0, 5000);
        repeat (500) @(negedge Clk);
        check("held_line_high", tx_a, 1);
        check("held_word_count", count_a, 1);
        expect_frame(0, frame_8n1(8'hC3), 10, 434, 1'b0, 0, 16'hC3);
        en_a = 1'b1;
        wait_drain(0, 5000);
        check("busy_after_held_word", busy_a, 0);
    endtask

    task automatic run_b();
        // Two stop bits at 9600
        en_b = 1'b1; baud_b = 3'b000; par_b = 2'b00; stop2_b = 1'b1;
        expect_frame(1, 16'b0000_0110_0000_0000, 11, 5208, 1'b0, 0, 16'h00);
        valid_b = 1'b1; din_b = 8'h00;
        @(negedge Clk);
        valid_b = 1'b0;
        wait_drain(1, 60000);
        check("slow_busy_after", busy_b, 0);
    endtask

    task automatic run_c();
        int t;
        en_c = 1'b1; baud_c = 3'b100; par_c = 2'b01; stop2_c = 1'b0;
        expect_frame(2, 16'b0000_0011_1111_1110, 10, 434, 1'b0, 0, 16'h7F);
        valid_c = 1'b1; din_c = 7'h7F;
        @(negedge Clk);
        valid_c = 1'b0;
        wait_drain(2, 6000);
        // Reset during the third data bit
        expect_frame(2, 16'b0000_0011_1111_1110, 10, 434, 1'b0, 3 * 434 + 5, 16'h17F);
        valid_c = 1'b1; din_c = 7'h7F;
        @(negedge Clk);
        @(negedge Clk);
        valid_c = 1'b0;
        t = 0;
        while (tx_c !== 1'b0 && t < 10) begin
            @(negedge Clk);
            t++;
        end
        check("db7_second_start_seen", tx_c, 0);
        repeat (3 * 434 + 5) @(negedge Clk);
        check("db7_count_before_reset", count_c, 1);
        #2 rst_c_n = 1'b0;
        #1;
        check("db7_reset_line_high", tx_c, 1);
        check("db7_reset_count_zero", count_c, 0);
        check("db7_reset_ready", ready_c, 1);
        @(negedge Clk);
        rst_c_n = 1'b1;
        repeat (1000) @(negedge Clk);
        check("db7_no_frame_after_reset", tx_c, 1);
        check("db7_count_after_reset", count_c, 0);
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        repeat (90000) @(posedge Clk);
        n_fail++;
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ab_n = 1'b0; rst_c_n = 1'b0;
        din_a = '0; din_b = '0; din_c = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        baud_a = 3'b100; baud_b = 3'b100; baud_c = 3'b100;
        par_a = '0; par_b = '0; par_c = '0;
        stop2_a = 1'b0; stop2_b = 1'b0; stop2_c = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_uart_tx", tx_a, 1);
        check("reset_tx_done", done_a, 0);
        check("reset_uart_state", busy_a, 0);
        check("reset_fifo_count", count_a, 0);
        check("reset_data_ready", ready_a, 1);
        rst_ab_n = 1'b1; rst_c_n = 1'b1;
        @(negedge Clk);
        fork
            run_a();
            run_b();
            run_c();
        join
        check("queue_main_empty", qsize(0), 0);
        check("queue_slow_empty", qsize(1), 0);
        check("queue_db7_empty", qsize(2), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
